cpu_rf_arb: RTL and testbench
=============================

# cpu_rf_arb

Arbiter and sequencer placed in front of the 16x32 CPU register file, which has two synchronous read ports, one write port, and R0 hardwired to zero. It shares the register file between two requesters:
- **A:** the CPU pipeline, which has priority.
- **B:** the host/DMA debug-access path.

The read-port pair and the write port are arbitrated independently, so both can be granted in the same cycle. The block forwards write data to a read granted in the same cycle and captures register-file write errors with the requester that caused them.

## Interface
- STARVE_MAX, default 4: number of consecutive cycles B may lose an arbitration before it is forced to win. Legal range is 1..15.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- a_rd_req, b_rd_req  in  1  read request; held until granted
- a_rd_sel1, a_rd_sel2, b_rd_sel1, b_rd_sel2  in  4  read register indices
- a_wr_req, b_wr_req  in  1  write request; held until granted
- a_wr_sel, b_wr_sel  in  4  write register index
- a_wr_data, b_wr_data  in  32  write data
- a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt  out  1  grant, combinational, same cycle as the request
- a_rvalid, b_rvalid  out  1  read data valid, one cycle after the read grant
- rdata1, rdata2  out  32  read data, shared by A and B and qualified by the rvalid signals
- rf_sel1, rf_sel2, rf_wrt_sel  out  4  register-file read and write selects
- rf_wrt_data  out  32  register-file write data
- rf_wrt_en  out  1  register-file write enable
- rf_reg1, rf_reg2  in  32  register-file read data, registered inside the register file
- rf_err  in  1  register-file error: non-zero data written to R0
- err_clr  in  1  clears the sticky error
- err_sticky  out  1  latched error flag
- err_src  out  1  requester that caused the latched error: 0 = A, 1 = B
- err_sel  out  4  write index that caused the latched error

## Operation
- **Read arbiter, one winner per cycle:**
  - If only one requester asks, it wins.
  - If both ask, A wins unless `b_rd_starve == STARVE_MAX`, in which case B wins.
  - The winner's sel1/sel2 drive `rf_sel1`/`rf_sel2`.
  - When no read is granted, the selects are driven to 0.
- **Write arbiter:** same rule, using its own counter `b_wr_starve`. The winner drives `rf_wrt_sel`, `rf_wrt_data` and `rf_wrt_en`=1. When no write is granted, `rf_wrt_en`=0 and the select and data are driven to 0.
- **Starvation counters:** each is 4 bits. A counter increments when B requests and is not granted. It clears when B is granted or B's request drops. It saturates at STARVE_MAX.
- **Read return:**
  - A pending flop records which requester got the read grant in cycle N.
  - In cycle N+1, exactly one of `a_rvalid`/`b_rvalid` is 1.
  - `rdata` is taken from `rf_reg1`/`rf_reg2`, subject to the bypass below.
- **Bypass:** the register file samples reads and writes at the same edge, so a read granted in the same cycle as a write returns the old value. The block corrects this:
  - If a read and a write are granted in the same cycle N with `rd_selX == wr_sel != 0`, then `rdataX` in N+1 is the write data.
  - The write data is latched in N. `rdata1` and `rdata2` are bypassed independently.
  - A read with sel = 0 always returns 0. A read granted in N+1 or later gets the new value from the register file.
- **Error capture:**
  - When `rf_err`=1 while `err_sticky`=0, the block latches `err_sticky`=1, `err_src` = the write winner, and `err_sel` = `rf_wrt_sel`.
  - Later errors do not overwrite the latched values; the first error is kept.
  - `err_clr` clears all three. If `err_clr` and a new `rf_err` occur in the same cycle, the new error is captured.
  - A write to R0 is still passed to the register file, which keeps R0 at zero.
- **Reset:**
  - All grants and rvalids are 0, the pending flop is idle, both counters are 0, `rdata` is 0, and `err_sticky`/`err_src`/`err_sel` are 0.
  - A read granted in the cycle an asynchronous reset asserts never produces an rvalid.

## Timing
- Grants are combinational from req inputs and starvation counters; no req-to-gnt flop.
- Read latency is exactly 1 cycle from grant to rvalid. Back-to-back reads are accepted every cycle, for full throughput.
- Writes take effect at the clock edge that ends the grant cycle.
- The error flag appears 1 cycle after the offending write grant.
- Outputs rvalid, rdata, err_* and the counters are flopped. Grants and the `rf_*` selects, data and enable are combinational.

## Test plan
- **Reset:** assert rst_n=0 mid-read, with `a_rd_gnt` in the previous cycle. Required: `a_rvalid`=0 the next cycle, every output is 0, and both counters are 0.
- **Same-cycle bypass:** A writes R5=0xDEADBEEF while B reads sel1=5, sel2=0 in the same cycle. Required: `b_rvalid`=1 next cycle with `rdata1`=0xDEADBEEF and `rdata2`=0. A repeated B read of R5 returns 0xDEADBEEF from the register file.
- **Starvation (STARVE_MAX=4):** A and B both hold `rd_req` continuously. Required: the grant sequence is A,A,A,A,B,A,A,A,A,B,... and B is never stalled more than 4 cycles.
- **Concurrency:** A reads R1/R2 while B writes R3 in the same cycle. Required: both are granted, `a_rvalid`=1 next cycle, and R3 is updated.
- **Error capture:**
  - B writes R0 with 0x1. Required: `err_sticky`=1, `err_src`=1, `err_sel`=0, and a later read of R0 returns 0.
  - A then writes R0 with 0x2. Required: `err_src` stays 1.
  - Assert `err_clr`. Required: all error outputs are 0.
- **Idle:** no requests. Required: `rf_wrt_en`=0, no rvalid, and the counters hold at 0.

Source files
------------

// File: rtl/cpu_rf_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cpu_rf_arb
// Purpose  : Two-requester arbiter/sequencer for the 16x32 CPU register file
//            with starvation guard, same-cycle write bypass and error capture.
// Revision : 1.0
// ============================================================================
module cpu_rf_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_rd_req,
    input  logic [3:0]  a_rd_sel1,
    input  logic [3:0]  a_rd_sel2,
    input  logic        b_rd_req,
    input  logic [3:0]  b_rd_sel1,
    input  logic [3:0]  b_rd_sel2,
    input  logic        a_wr_req,
    input  logic [3:0]  a_wr_sel,
    input  logic [31:0] a_wr_data,
    input  logic        b_wr_req,
    input  logic [3:0]  b_wr_sel,
    input  logic [31:0] b_wr_data,
    output logic        a_rd_gnt,
    output logic        b_rd_gnt,
    output logic        a_wr_gnt,
    output logic        b_wr_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [3:0]  rf_sel1,
    output logic [3:0]  rf_sel2,
    output logic [3:0]  rf_wrt_sel,
    output logic [31:0] rf_wrt_data,
    output logic        rf_wrt_en,
    input  logic [31:0] rf_reg1,
    input  logic [31:0] rf_reg2,
    input  logic        rf_err,
    input  logic        err_clr,
    output logic        err_sticky,
    output logic        err_src,
    output logic [3:0]  err_sel
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]  r_b_rd_starve;
    logic [3:0]  r_b_wr_starve;
    logic        w_b_rd_win;
    logic        w_b_wr_win;
    logic        w_rd_any;
    logic        w_byp1;
    logic        w_byp2;

    logic        r_a_pend;
    logic        r_b_pend;
    logic        r_byp1;
    logic        r_byp2;
    logic        r_zero1;
    logic        r_zero2;
    logic [31:0] r_byp_data;

    logic        r_err_sticky;
    logic        r_err_src;
    logic [3:0]  r_err_sel;

    // B wins when uncontested or when it has lost STARVE_MAX times in a row
    assign w_b_rd_win = b_rd_req && (!a_rd_req || (r_b_rd_starve == C_STARVE_MAX));
    assign w_b_wr_win = b_wr_req && (!a_wr_req || (r_b_wr_starve == C_STARVE_MAX));

    assign b_rd_gnt = w_b_rd_win;
    assign a_rd_gnt = a_rd_req && !w_b_rd_win;
    assign b_wr_gnt = w_b_wr_win;
    assign a_wr_gnt = a_wr_req && !w_b_wr_win;

    always_comb begin
        rf_sel1     = '0;
        rf_sel2     = '0;
        rf_wrt_sel  = '0;
        rf_wrt_data = '0;
        rf_wrt_en   = 1'b0;
        if (a_rd_gnt) begin
            rf_sel1 = a_rd_sel1;
            rf_sel2 = a_rd_sel2;
        end else if (b_rd_gnt) begin
            rf_sel1 = b_rd_sel1;
            rf_sel2 = b_rd_sel2;
        end
        if (a_wr_gnt) begin
            rf_wrt_sel  = a_wr_sel;
            rf_wrt_data = a_wr_data;
            rf_wrt_en   = 1'b1;
        end else if (b_wr_gnt) begin
            rf_wrt_sel  = b_wr_sel;
            rf_wrt_data = b_wr_data;
            rf_wrt_en   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_rd_starve <= '0;
            r_b_wr_starve <= '0;
        end else begin
            if (b_rd_req && !b_rd_gnt) begin
                if (r_b_rd_starve < C_STARVE_MAX)
                    r_b_rd_starve <= r_b_rd_starve + 4'd1;
            end else begin
                r_b_rd_starve <= '0;
            end
            if (b_wr_req && !b_wr_gnt) begin
                if (r_b_wr_starve < C_STARVE_MAX)
                    r_b_wr_starve <= r_b_wr_starve + 4'd1;
            end else begin
                r_b_wr_starve <= '0;
            end
        end
    end

    // The RF samples reads and writes at the same edge, so a colliding read
    // would return stale data; remember the collision and substitute.
    assign w_rd_any = a_rd_gnt || b_rd_gnt;
    assign w_byp1   = w_rd_any && rf_wrt_en && (rf_wrt_sel != 4'd0) && (rf_sel1 == rf_wrt_sel);
    assign w_byp2   = w_rd_any && rf_wrt_en && (rf_wrt_sel != 4'd0) && (rf_sel2 == rf_wrt_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_pend   <= 1'b0;
            r_b_pend   <= 1'b0;
            r_byp1     <= 1'b0;
            r_byp2     <= 1'b0;
            r_zero1    <= 1'b0;
            r_zero2    <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_a_pend <= a_rd_gnt;
            r_b_pend <= b_rd_gnt;
            r_byp1   <= w_byp1;
            r_byp2   <= w_byp2;
            r_zero1  <= (rf_sel1 == 4'd0);
            r_zero2  <= (rf_sel2 == 4'd0);
            if (w_byp1 || w_byp2)
                r_byp_data <= rf_wrt_data;
        end
    end

    assign a_rvalid = r_a_pend;
    assign b_rvalid = r_b_pend;

    // rf_reg* are already registered in the RF; only the select mux is added here
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (r_a_pend || r_b_pend) begin
            if (!r_zero1)
                rdata1 = r_byp1 ? r_byp_data : rf_reg1;
            if (!r_zero2)
                rdata2 = r_byp2 ? r_byp_data : rf_reg2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_src    <= 1'b0;
            r_err_sel    <= '0;
        end else if (rf_err && (err_clr || !r_err_sticky)) begin
            r_err_sticky <= 1'b1;
            r_err_src    <= b_wr_gnt;
            r_err_sel    <= rf_wrt_sel;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_src    <= 1'b0;
            r_err_sel    <= '0;
        end
    end

    assign err_sticky = r_err_sticky;
    assign err_src    = r_err_src;
    assign err_sel    = r_err_sel;

endmodule
`default_nettype wire

// File: tb/tb_cpu_rf_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_rf_arb
// Purpose  : Scoreboard bench for cpu_rf_arb with a behavioural register file.
// Revision : 1.0
// ============================================================================
module tb_cpu_rf_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_rd_req = 1'b0, b_rd_req = 1'b0, a_wr_req = 1'b0, b_wr_req = 1'b0;
    logic [3:0]  a_rd_sel1 = '0, a_rd_sel2 = '0, b_rd_sel1 = '0, b_rd_sel2 = '0;
    logic [3:0]  a_wr_sel = '0, b_wr_sel = '0;
    logic [31:0] a_wr_data = '0, b_wr_data = '0;
    logic        err_clr = 1'b0;
    logic        a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt, a_rvalid, b_rvalid;
    logic [31:0] rdata1, rdata2, rf_wrt_data, rf_reg1, rf_reg2;
    logic [3:0]  rf_sel1, rf_sel2, rf_wrt_sel, err_sel;
    logic        rf_wrt_en, rf_err, err_sticky, err_src;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic        src;
        logic [31:0] d1;
        logic [31:0] d2;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t m_e;

    logic [31:0] mem [16];

    cpu_rf_arb #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_rd_req(a_rd_req), .a_rd_sel1(a_rd_sel1), .a_rd_sel2(a_rd_sel2),
        .b_rd_req(b_rd_req), .b_rd_sel1(b_rd_sel1), .b_rd_sel2(b_rd_sel2),
        .a_wr_req(a_wr_req), .a_wr_sel(a_wr_sel), .a_wr_data(a_wr_data),
        .b_wr_req(b_wr_req), .b_wr_sel(b_wr_sel), .b_wr_data(b_wr_data),
        .a_rd_gnt(a_rd_gnt), .b_rd_gnt(b_rd_gnt), .a_wr_gnt(a_wr_gnt), .b_wr_gnt(b_wr_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata1(rdata1), .rdata2(rdata2),
        .rf_sel1(rf_sel1), .rf_sel2(rf_sel2), .rf_wrt_sel(rf_wrt_sel),
        .rf_wrt_data(rf_wrt_data), .rf_wrt_en(rf_wrt_en),
        .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_err(rf_err),
        .err_clr(err_clr), .err_sticky(err_sticky), .err_src(err_src), .err_sel(err_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous reads, R0 stays zero, flags non-zero writes to R0
    assign rf_err = rf_wrt_en && (rf_wrt_sel == 4'd0) && (rf_wrt_data != 32'd0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            rf_reg1 <= '0;
            rf_reg2 <= '0;
        end else begin
            rf_reg1 <= mem[rf_sel1];
            rf_reg2 <= mem[rf_sel2];
            if (rf_wrt_en && rf_wrt_sel != 4'd0) mem[rf_wrt_sel] <= rf_wrt_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (a_rvalid || b_rvalid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rvalid_unexpected: got a_rvalid=%0b b_rvalid=%0b required none", a_rvalid, b_rvalid);
            end else begin
                m_e = exp_q.pop_front();
                chk("rv_latency", 32'(cyc), 32'(m_e.cyc));
                chk("rv_both", {31'd0, a_rvalid & b_rvalid}, 32'd0);
                chk("rv_src", {31'd0, b_rvalid}, {31'd0, m_e.src});
                chk("rdata1", rdata1, m_e.d1);
                chk("rdata2", rdata2, m_e.d2);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            total_cnt++;
            $display("FAIL rvalid_missing: got no rvalid required src=%0b", exp_q[0].src);
            m_e = exp_q.pop_front();
        end
    end

    // One arbitration cycle; erg/ewg are {A,B} expected grants
    task automatic step(
        input logic ar, input logic [3:0] as1, input logic [3:0] as2,
        input logic br, input logic [3:0] bs1, input logic [3:0] bs2,
        input logic aw, input logic [3:0] aws, input logic [31:0] awd,
        input logic bw, input logic [3:0] bws, input logic [31:0] bwd,
        input logic [1:0] erg, input logic [1:0] ewg,
        input logic [31:0] ed1, input logic [31:0] ed2);
        logic [3:0]  es1, es2, ews;
        logic [31:0] ewd;
        a_rd_req = ar; a_rd_sel1 = as1; a_rd_sel2 = as2;
        b_rd_req = br; b_rd_sel1 = bs1; b_rd_sel2 = bs2;
        a_wr_req = aw; a_wr_sel = aws; a_wr_data = awd;
        b_wr_req = bw; b_wr_sel = bws; b_wr_data = bwd;
        es1 = erg[1] ? as1 : (erg[0] ? bs1 : 4'd0);
        es2 = erg[1] ? as2 : (erg[0] ? bs2 : 4'd0);
        ews = ewg[1] ? aws : (ewg[0] ? bws : 4'd0);
        ewd = ewg[1] ? awd : (ewg[0] ? bwd : 32'd0);
        @(negedge clk);
        chk("a_rd_gnt", {31'd0, a_rd_gnt}, {31'd0, erg[1]});
        chk("b_rd_gnt", {31'd0, b_rd_gnt}, {31'd0, erg[0]});
        chk("a_wr_gnt", {31'd0, a_wr_gnt}, {31'd0, ewg[1]});
        chk("b_wr_gnt", {31'd0, b_wr_gnt}, {31'd0, ewg[0]});
        chk("rf_sel1", {28'd0, rf_sel1}, {28'd0, es1});
        chk("rf_sel2", {28'd0, rf_sel2}, {28'd0, es2});
        chk("rf_wrt_en", {31'd0, rf_wrt_en}, {31'd0, |ewg});
        chk("rf_wrt_sel", {28'd0, rf_wrt_sel}, {28'd0, ews});
        chk("rf_wrt_data", rf_wrt_data, ewd);
        if (erg != 2'b00)
            exp_q.push_back('{src: erg[0], d1: ed1, d2: ed2, cyc: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_gnts", {28'd0, a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt}, 32'd0);
        chk("rst_rf_wrt_en", {31'd0, rf_wrt_en}, 32'd0);
        chk("rst_rf_sels", {20'd0, rf_sel1, rf_sel2, rf_wrt_sel}, 32'd0);
        chk("rst_rf_wrt_data", rf_wrt_data, 32'd0);
        chk("rst_err", {26'd0, err_sticky, err_src, err_sel}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read granted, then asynchronous reset lands in the grant cycle
        step(1, 1, 2, 1, 3, 4, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        a_rd_req = 1'b1; a_rd_sel1 = 4'd1; a_rd_sel2 = 4'd2;
        b_rd_req = 1'b1; b_rd_sel1 = 4'd3; b_rd_sel2 = 4'd4;
        @(negedge clk);
        chk("pre_rst_a_rd_gnt", {31'd0, a_rd_gnt}, 32'd1);
        #1;
        rst_n = 1'b0;
        a_rd_req = 1'b0; b_rd_req = 1'b0;
        a_rd_sel1 = '0; a_rd_sel2 = '0; b_rd_sel1 = '0; b_rd_sel2 = '0;
        @(posedge clk);
        #1;
        chk_zero_outputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Starvation: counter must restart from 0 after reset
        for (int i = 0; i < 10; i++)
            step(1, 1, 2, 1, 3, 4, 0, 0, 0, 0, 0, 0,
                 (i % 5 == 4) ? 2'b01 : 2'b10, 2'b00, 0, 0);

        idle();
        idle();
        chk("idle_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);

        // Concurrency: A reads while B writes
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h1111_1111, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2, 32'h2222_2222, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 3, 32'h3333_3333, 2'b10, 2'b01,
             32'h1111_1111, 32'h2222_2222);
        step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h3333_3333, 0);

        // Bypass cases
        step(0, 0, 0, 1, 5, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 2'b01, 2'b10, 32'hDEAD_BEEF, 0);
        step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'hDEAD_BEEF, 0);
        step(1, 5, 6, 0, 0, 0, 1, 6, 32'h1234_5678, 0, 0, 0, 2'b10, 2'b10,
             32'hDEAD_BEEF, 32'h1234_5678);
        step(1, 7, 7, 0, 0, 0, 0, 0, 0, 1, 7, 32'hCAFE_F00D, 2'b10, 2'b01,
             32'hCAFE_F00D, 32'hCAFE_F00D);
        step(0, 0, 0, 1, 7, 9, 1, 8, 32'hA5A5_A5A5, 0, 0, 0, 2'b01, 2'b10, 32'hCAFE_F00D, 0);

        // Write contention and write-side starvation
        step(0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 9, 32'h99, 2'b00, 2'b10, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 2'b00, 2'b01, 0, 0);
        step(1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h44, 32'h99);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 0, 1, 10, 32'(i), 1, 11, 32'hB0B, 2'b00,
                 (i == 4) ? 2'b01 : 2'b10, 0, 0);
        step(1, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'd3, 32'hB0B);

        // Error capture
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1, 2'b00, 2'b01, 0, 0);
        chk("err_sticky_b", {31'd0, err_sticky}, 32'd1);
        chk("err_src_b", {31'd0, err_src}, 32'd1);
        chk("err_sel_b", {28'd0, err_sel}, 32'd0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h2, 0, 0, 0, 2'b10, 2'b10, 0, 0);
        chk("err_keep_sticky", {31'd0, err_sticky}, 32'd1);
        chk("err_keep_src", {31'd0, err_src}, 32'd1);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        chk("err_clr", {26'd0, err_sticky, err_src, err_sel}, 32'd0);
        err_clr = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1, 0, 32'h3, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        err_clr = 1'b0;
        chk("err_clr_and_new_sticky", {31'd0, err_sticky}, 32'd1);
        chk("err_clr_and_new_src", {31'd0, err_src}, 32'd0);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        chk("err_clr2", {26'd0, err_sticky, err_src, err_sel}, 32'd0);

        idle();
        idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
